game_config_select: RTL

//  Parametrised game-setup menu for Flood-It: debounces the five pushbuttons, edits board SIZE
//  and COLOR_NUM within configurable ranges (with wrap and hold-to-repeat), computes the move

---
 rtl/game_config_select_if.sv | 45 ++++
 rtl/game_config_select.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/game_config_select_if.sv
// Interface: game_config_select_if
// Bundles the Flood-It setup-menu signals into one port.
//   Buttons (menu inputs) : up, down, left, right, center  -- raw async pushbuttons, active-high
//   Handshake in          : board_ready, ack_begin_game, game_over
//   Menu outputs          : size[4:0], color_num[3:0], field_sel
//   Latched game config   : final_size[4:0], final_color_num[3:0], total_tries[7:0]
//   Handshake out         : initialize_board, begin_game, mode
// Modports:
//   master -- the menu block (drives the outputs, reads buttons/handshake)
//   slave  -- the environment (buttons, board generator, game core)
interface game_config_select_if;
    logic       up;
    logic       down;
    logic       left;
    logic       right;
    logic       center;
    logic       board_ready;
    logic       ack_begin_game;
    logic       game_over;
    logic [4:0] size;
    logic [3:0] color_num;
    logic       field_sel;
    logic [4:0] final_size;
    logic [3:0] final_color_num;
    logic [7:0] total_tries;
    logic       initialize_board;
    logic       begin_game;
    logic       mode;

    modport master (
        input  up, down, left, right, center,
        input  board_ready, ack_begin_game, game_over,
        output size, color_num, field_sel,
        output final_size, final_color_num, total_tries,
        output initialize_board, begin_game, mode
    );

    modport slave (
        output up, down, left, right, center,
        output board_ready, ack_begin_game, game_over,
        input  size, color_num, field_sel,
        input  final_size, final_color_num, total_tries,
        input  initialize_board, begin_game, mode
    );
endinterface

// File: rtl/game_config_select.sv
// Module: game_config_select
// Flood-It game-setup menu. Debounces five pushbuttons, lets the player edit the board
// size and colour count (wrap-around, hold-to-repeat on UP/DOWN), computes the move
// budget and runs the setup -> init -> begin -> play handshake with the board/game core.
// Ports:
//   clk_i    in  system clock
//   rst_i    in  asynchronous active-high reset
//   cfg_bus  game_config_select_if.master
//            in : up/down/left/right/center buttons, board_ready, ack_begin_game, game_over
//            out: size, color_num, field_sel (0 = colour count, 1 = size),
//                 final_size, final_color_num, total_tries (latched at game start),
//                 initialize_board, begin_game (level requests), mode (0 = menu, 1 = game)
module game_config_select #(
    parameter int SIZE_MIN      = 2,
    parameter int SIZE_MAX      = 26,
    parameter int SIZE_STEP     = 4,
    parameter int COLOR_MIN     = 3,
    parameter int COLOR_MAX     = 8,
    parameter int DEB_CYCLES    = 100000,
    parameter int HOLD_CYCLES   = 50000000,
    parameter int REPEAT_CYCLES = 10000000,
    parameter int TRIES_NUM     = 5,
    parameter int TRIES_SHIFT   = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    game_config_select_if.master cfg_bus
);

    localparam int NBTN    = 5;
    localparam int BTN_UP  = 0;
    localparam int BTN_DN  = 1;
    localparam int BTN_LF  = 2;
    localparam int BTN_RT  = 3;
    localparam int BTN_CE  = 4;
    localparam int DEB_W   = $clog2(DEB_CYCLES + 1);
    localparam int REP_W   = $clog2(HOLD_CYCLES + 1);

    localparam logic [4:0] RST_SIZE  = 5'd14;
    localparam logic [3:0] RST_COLOR = 4'd6;
    localparam logic [7:0] RST_TRIES = 8'd26;

    typedef enum logic [1:0] {ST_SETUP, ST_INIT, ST_START, ST_PLAY} state_t;

    logic [NBTN-1:0] btn_raw;
    logic [NBTN-1:0] press_vec;   // one-cycle debounced press pulses
    logic [1:0]      held_vec;    // debounced levels of UP/DOWN
    logic [1:0]      rep_vec;     // auto-repeat pulses of UP/DOWN

    assign btn_raw = {cfg_bus.center, cfg_bus.right, cfg_bus.left, cfg_bus.down, cfg_bus.up};

    // Synchroniser + debounce + rising-edge pulse, one instance per button.
    // The counter runs only while the synchronised level differs from the accepted
    // level, so any bounce back to the accepted level restarts it.
    for (genvar gi = 0; gi < NBTN; gi++) begin : g_btn
        logic             sync1_q;
        logic             sync2_q;
        logic             stable_q;
        logic             press_q;
        logic [DEB_W-1:0] deb_cnt_q;

        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                sync1_q   <= 1'b0;
                sync2_q   <= 1'b0;
                stable_q  <= 1'b0;
                press_q   <= 1'b0;
                deb_cnt_q <= '0;
            end else begin
                sync1_q <= btn_raw[gi];
                sync2_q <= sync1_q;
                press_q <= 1'b0;
                if (sync2_q == stable_q) begin
                    deb_cnt_q <= '0;
                end else if (deb_cnt_q == DEB_W'(DEB_CYCLES - 1)) begin
                    stable_q  <= sync2_q;
                    press_q   <= sync2_q;
                    deb_cnt_q <= '0;
                end else begin
                    deb_cnt_q <= deb_cnt_q + DEB_W'(1);
                end
            end
        end

        assign press_vec[gi] = press_q;

        if (gi < 2) begin : g_held
            assign held_vec[gi] = stable_q;
        end
    end

    // Auto-repeat for UP/DOWN. The counter starts from zero on the press edge; the
    // first extra pulse fires HOLD_CYCLES later, after which the counter is rewound
    // so that it reaches HOLD_CYCLES again every REPEAT_CYCLES.
    for (genvar gi = 0; gi < 2; gi++) begin : g_rep
        logic [REP_W-1:0] rep_cnt_q;
        logic [REP_W-1:0] rep_inc;
        logic             rep_q;

        assign rep_inc = rep_cnt_q + REP_W'(1);

        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                rep_cnt_q <= '0;
                rep_q     <= 1'b0;
            end else begin
                rep_q <= 1'b0;
                if (!held_vec[gi]) begin
                    rep_cnt_q <= '0;
                end else if (rep_inc == REP_W'(HOLD_CYCLES)) begin
                    rep_q     <= 1'b1;
                    rep_cnt_q <= REP_W'(HOLD_CYCLES - REPEAT_CYCLES);
                end else begin
                    rep_cnt_q <= rep_inc;
                end
            end
        end

        assign rep_vec[gi] = rep_q;
    end

    logic up_evt;
    logic dn_evt;
    assign up_evt = press_vec[BTN_UP] | rep_vec[BTN_UP];
    assign dn_evt = press_vec[BTN_DN] | rep_vec[BTN_DN];

    // Step up with wrap; a value outside [lo,hi] snaps to lo.
    function automatic int wrap_up(input int v, input int lo, input int hi, input int st);
        if (v < lo || v > hi) return lo;
        if (v == hi)          return lo;
        if (v + st > hi)      return hi;
        return v + st;
    endfunction

    // Step down with wrap; a value outside [lo,hi] snaps to lo.
    function automatic int wrap_dn(input int v, input int lo, input int hi, input int st);
        if (v < lo || v > hi) return lo;
        if (v == lo)          return hi;
        if (v - st < lo)      return lo;
        return v - st;
    endfunction

    // Move budget: (size * colours * TRIES_NUM) >> TRIES_SHIFT, floored at 1, saturated at 255.
    function automatic logic [7:0] calc_tries(input logic [4:0] s, input logic [3:0] c);
        logic [15:0] prod;
        logic [15:0] shifted;
        prod    = 16'(s) * 16'(c) * 16'(TRIES_NUM);
        shifted = prod >> TRIES_SHIFT;
        if (shifted == 16'd0)   return 8'd1;
        if (shifted > 16'd255)  return 8'hFF;
        return shifted[7:0];
    endfunction

    state_t     state_q, state_d;
    logic [4:0] size_q, size_d;
    logic [3:0] color_q, color_d;
    logic       field_sel_q, field_sel_d;
    logic [4:0] final_size_q, final_size_d;
    logic [3:0] final_color_q, final_color_d;
    logic [7:0] tries_q, tries_d;
    logic       init_q, init_d;
    logic       begin_q, begin_d;
    logic       mode_q, mode_d;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q       <= ST_SETUP;
            size_q        <= RST_SIZE;
            color_q       <= RST_COLOR;
            field_sel_q   <= 1'b0;
            final_size_q  <= RST_SIZE;
            final_color_q <= RST_COLOR;
            tries_q       <= RST_TRIES;
            init_q        <= 1'b0;
            begin_q       <= 1'b0;
            mode_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            size_q        <= size_d;
            color_q       <= color_d;
            field_sel_q   <= field_sel_d;
            final_size_q  <= final_size_d;
            final_color_q <= final_color_d;
            tries_q       <= tries_d;
            init_q        <= init_d;
            begin_q       <= begin_d;
            mode_q        <= mode_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        size_d        = size_q;
        color_d       = color_q;
        field_sel_d   = field_sel_q;
        final_size_d  = final_size_q;
        final_color_d = final_color_q;
        tries_d       = tries_q;
        init_d        = init_q;
        begin_d       = begin_q;

        unique case (state_q)
            ST_SETUP: begin
                if (press_vec[BTN_CE]) begin
                    final_size_d  = size_q;
                    final_color_d = color_q;
                    tries_d       = calc_tries(size_q, color_q);
                    init_d        = 1'b1;
                    state_d       = ST_INIT;
                end else begin
                    // Simultaneous UP and DOWN cancel. The edit uses the selection
                    // as it was before any coincident LEFT toggle.
                    if (up_evt != dn_evt) begin
                        if (field_sel_q) begin
                            size_d = up_evt
                                ? 5'(wrap_up(int'(size_q), SIZE_MIN, SIZE_MAX, SIZE_STEP))
                                : 5'(wrap_dn(int'(size_q), SIZE_MIN, SIZE_MAX, SIZE_STEP));
                        end else begin
                            color_d = up_evt
                                ? 4'(wrap_up(int'(color_q), COLOR_MIN, COLOR_MAX, 1))
                                : 4'(wrap_dn(int'(color_q), COLOR_MIN, COLOR_MAX, 1));
                        end
                    end
                    if (press_vec[BTN_LF]) begin
                        field_sel_d = ~field_sel_q;
                    end
                end
            end
            ST_INIT: begin
                if (cfg_bus.board_ready) begin
                    begin_d = 1'b1;
                    state_d = ST_START;
                end
            end
            ST_START: begin
                if (cfg_bus.ack_begin_game) begin
                    begin_d = 1'b0;
                    init_d  = 1'b0;
                    state_d = ST_PLAY;
                end
            end
            ST_PLAY: begin
                if (press_vec[BTN_RT] || cfg_bus.game_over) begin
                    state_d = ST_SETUP;
                end
            end
            default: state_d = ST_SETUP;
        endcase

        mode_d = (state_d != ST_SETUP);
    end

    assign cfg_bus.size             = size_q;
    assign cfg_bus.color_num        = color_q;
    assign cfg_bus.field_sel        = field_sel_q;
    assign cfg_bus.final_size       = final_size_q;
    assign cfg_bus.final_color_num  = final_color_q;
    assign cfg_bus.total_tries      = tries_q;
    assign cfg_bus.initialize_board = init_q;
    assign cfg_bus.begin_game       = begin_q;
    assign cfg_bus.mode             = mode_q;

endmodule
